axi_spill_mem_slave: RTL and testbench
======================================

Name: axi_spill_mem_slave

Overview:
AXI4 slave (responder) backed by on-chip block RAM. It is the far end of the buffer manager's spill/fill master port: it accepts INCR write bursts (spill) and read bursts (fill). It lets the spill path be tested and run without DDR, and can stand in for the DDR window at SPILL_BASE. Read and write channels are independent; each has one transaction outstanding at a time.

Parameters:
DATA_WIDTH, 64, AXI data width in bits (matches `AXI_DATA_WIDTH); must be a power of 2, 32 or wider.
ADDR_WIDTH, 32, AXI address width.
MEM_DEPTH, 1024, number of DATA_WIDTH words; must be a power of 2.
BASE_ADDR, 32'h10000000, byte address of word 0.

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s_axi_awaddr  in  ADDR_WIDTH  write burst start address
s_axi_awlen  in  8  beats minus 1
s_axi_awsize  in  3  beat size
s_axi_awburst  in  2  burst type
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_WIDTH  read burst start address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize  in  3  beat size
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset: all ready/valid outputs are 0; bresp, rresp, rlast and rdata are 0; both FSMs are in IDLE. Memory contents are not reset. Reset mid-burst abandons the burst; the master must also be reset.
- Address map: word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). A beat is in range if addr >= BASE_ADDR and word index < MEM_DEPTH. The index is recomputed per beat and incremented by 1 each beat.
- Error conditions (any one makes the burst an error burst):
  - awburst/arburst is not INCR (2'b01);
  - awsize/arsize is not log2(DATA_WIDTH/8);
  - any beat is out of range.
- Error burst handling: the burst still completes its full beat count. Writes in an error burst are suppressed for the whole burst. Read beats return data 0.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch address and length, then go to W_DATA.
  - W_DATA: wready=1. Each accepted beat writes the bytes enabled by wstrb.
  - On the beat where the count reaches awlen: go to W_RESP. If wlast is not 1 on that beat, or wlast=1 on an earlier beat, the response is SLVERR (2'b10) and the burst still ends at awlen+1 beats.
  - W_RESP: bvalid=1 with bresp = OKAY (2'b00) or SLVERR, held until bready, then go to W_IDLE.
  - Best case is 1 cycle from AW to the first W beat.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch the burst and issue the RAM read, then go to R_DATA.
  - R_DATA: rvalid rises exactly 1 cycle after the AR handshake (synchronous RAM).
  - rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
  - On rvalid&rready, the next beat is presented the next cycle with no bubble (one-beat prefetch; RAM read enable is gated by a stall).
  - rlast=1 on beat arlen. After the last handshake, go to R_IDLE.
  - arready=0 until R_IDLE is re-entered.
- Collisions: a simultaneous read and write to the same word returns the old data (read-before-write). Both channels may be active in the same cycle.
- Max burst is 256 beats; beat counters are 8 bits and do not wrap within a burst.

Test Plan:
- Single write then read: AW addr 0x10000000, len 0, wdata 0x1122334455667788, wstrb 0xFF -> bresp 0; AR same address -> rvalid 1 cycle after AR, rdata 0x1122334455667788, rlast 1, rresp 0.
- 16-beat INCR write of values 0..15 at 0x10000040, then 16-beat read with rready toggled 1/0 -> data 0..15 in order, no duplicates or drops, rlast only on beat 16.
- Partial strobe: after word = all-ones, write 0x0 with wstrb 0x0F -> readback 0xFFFFFFFF00000000.
- Out-of-range/bad burst: AW at 0x0FFFFFF8, or arburst=2'b10 -> bresp/rresp 2'b10, memory unchanged, full beat count honoured, rdata 0.
- wlast mismatch: awlen 3 with wlast on beat 2 -> 4 beats accepted, bresp SLVERR.
- Concurrent write and read to the same word, plus assert areset mid-read-burst -> the read returns the old value; after reset rvalid=0, arready=1 in the following cycle, and a new burst succeeds.

Source files
------------

// File: rtl/axi_spill_mem_slave.sv
// AXI4 responder backed by an on-chip block RAM. It is the far end of the
// buffer manager's spill/fill port and can stand in for the DDR window at
// BASE_ADDR. Read and write channels are independent. Each channel has one
// burst outstanding at a time.
//
// Ports:
//   aclk, areset          clock and synchronous active-high reset
//   s_axi_aw*             write address channel (INCR, full-width beats only)
//   s_axi_w*              write data channel with byte strobes
//   s_axi_b*              write response (OKAY / SLVERR)
//   s_axi_ar*             read address channel
//   s_axi_r*              read data channel (one-beat prefetch, no bubbles)
module axi_spill_mem_slave #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h10000000
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int         BYTES       = DATA_WIDTH / 8;
  localparam int         SHIFT       = $clog2(BYTES);
  localparam int         IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE   = 3'(SHIFT);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Beats advance one word at a time, so the whole burst is in range exactly
  // when its first and last words are. Deciding this at the address phase
  // lets an error burst be suppressed from its very first beat.
  function automatic logic burst_ok(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [7:0] len,
                                    input logic [2:0] size,
                                    input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] word;
    logic [ADDR_WIDTH:0]   last_word;
    word      = (addr - BASE_ADDR) >> SHIFT;
    last_word = {1'b0, word} + {{(ADDR_WIDTH-7){1'b0}}, len};
    return (burst == BURST_INCR) && (size == FULL_SIZE) &&
           (addr >= BASE_ADDR) && (last_word < (ADDR_WIDTH+1)'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] start_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> SHIFT);
  endfunction

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t         w_state_reg, w_state_next;
  logic [IDX_W-1:0] w_idx_reg;
  logic [7:0]       w_len_reg, w_cnt_reg;
  logic             w_err_reg, w_last_err_reg;
  logic             aw_hs, w_hs, w_final, mem_we;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_final = (w_cnt_reg == w_len_reg);
  assign mem_we  = w_hs && !w_err_reg;

  always_ff @(posedge aclk) begin
    if (areset) w_state_reg <= W_IDLE;
    else        w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (s_axi_awvalid)           w_state_next = W_DATA;
      W_DATA:  if (s_axi_wvalid && w_final) w_state_next = W_RESP;
      W_RESP:  if (s_axi_bready)            w_state_next = W_IDLE;
      default:                              w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (w_state_reg == W_IDLE);
    s_axi_wready  = (w_state_reg == W_DATA);
    s_axi_bvalid  = (w_state_reg == W_RESP);
    s_axi_bresp   = (s_axi_bvalid && (w_err_reg || w_last_err_reg)) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_idx_reg      <= '0;
      w_len_reg      <= '0;
      w_cnt_reg      <= '0;
      w_err_reg      <= 1'b0;
      w_last_err_reg <= 1'b0;
    end else if (aw_hs) begin
      w_idx_reg      <= start_idx(s_axi_awaddr);
      w_len_reg      <= s_axi_awlen;
      w_cnt_reg      <= '0;
      w_err_reg      <= !burst_ok(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
      w_last_err_reg <= 1'b0;
    end else if (w_hs) begin
      w_idx_reg      <= w_idx_reg + IDX_W'(1);
      w_cnt_reg      <= w_cnt_reg + 8'd1;
      // The burst length comes from awlen alone. A wlast that is early or
      // missing only flags the response.
      w_last_err_reg <= w_last_err_reg | (w_final ? !s_axi_wlast : s_axi_wlast);
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t         r_state_reg, r_state_next;
  logic [IDX_W-1:0] r_idx_reg, rd_idx;
  logic [7:0]       r_len_reg, r_cnt_reg;
  logic             r_err_reg, ar_hs, r_hs, r_final, rd_en;
  logic [DATA_WIDTH-1:0] ram_q;

  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign r_final = (r_cnt_reg == r_len_reg);
  // The RAM output register holds the beat on the bus. It only advances on
  // the AR handshake or when the current beat is taken, which keeps rdata
  // stable under back-pressure and gives the next beat with no bubble.
  assign rd_en   = ar_hs || (r_hs && !r_final);
  assign rd_idx  = (r_state_reg == R_IDLE) ? start_idx(s_axi_araddr) : r_idx_reg + IDX_W'(1);

  always_ff @(posedge aclk) begin
    if (areset) r_state_reg <= R_IDLE;
    else        r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (s_axi_arvalid)           r_state_next = R_DATA;
      R_DATA:  if (s_axi_rready && r_final) r_state_next = R_IDLE;
      default:                              r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_state_reg == R_IDLE);
    s_axi_rvalid  = (r_state_reg == R_DATA);
    s_axi_rlast   = s_axi_rvalid && r_final;
    s_axi_rresp   = (s_axi_rvalid && r_err_reg) ? RESP_SLVERR : RESP_OKAY;
    s_axi_rdata   = (s_axi_rvalid && !r_err_reg) ? ram_q : '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_idx_reg <= '0;
      r_len_reg <= '0;
      r_cnt_reg <= '0;
      r_err_reg <= 1'b0;
    end else begin
      if (rd_en) r_idx_reg <= rd_idx;
      if (ar_hs) begin
        r_len_reg <= s_axi_arlen;
        r_cnt_reg <= '0;
        r_err_reg <= !burst_ok(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
      end else if (r_hs) begin
        r_cnt_reg <= r_cnt_reg + 8'd1;
      end
    end
  end

  // ---------------- storage ----------------
  // The read and the write share one clocked process. A same-word collision
  // therefore returns the old contents (read-before-write).
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge aclk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (mem_we && s_axi_wstrb[b]) mem[w_idx_reg][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
    if (rd_en) ram_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi_spill_mem_slave.sv
module tb_axi_spill_mem_slave;
  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;

  int checks = 0, passed = 0;

  logic [63:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];
  logic        rd_last_q[$];
  int          hold_bad;
  logic        first_valid;
  logic        trailing_valid;
  logic [1:0]  t_resp;
  int          t_beats;
  logic        t_ok;

  always #5 clk = ~clk;

  axi_spill_mem_slave dut (
    .aclk(clk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  // Write burst: beat i carries d0+i; wlast is driven on beat wlast_at.
  // beats counts accepted beats, plus one if wready is still high after len+1.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [63:0] d0, input logic [7:0] strb,
                          input int wlast_at, output logic [1:0] resp,
                          output int beats, output logic ok);
    int guard;
    ok = 1'b1; beats = 0; resp = 2'b11;
    @(negedge clk);
    awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 50) begin @(negedge clk); guard++; end
    if (!awready) ok = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + 64'(i); wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
      guard = 0;
      while (!wready && guard < 50) begin @(negedge clk); guard++; end
      if (wready) beats++; else ok = 1'b0;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (wready) beats++;
    bready = 1'b1;
    guard = 0;
    while (!bvalid && guard < 50) begin @(negedge clk); guard++; end
    if (bvalid) resp = bresp; else ok = 1'b0;
    @(negedge clk);
    bready = 1'b0;
    $display("write addr=%h len=%0d bresp=%0d beats=%0d", addr, len, resp, beats);
  endtask

  // Read burst: collects accepted beats into the queues; with toggle set,
  // rready alternates 1/0 and stalled beats are checked for stability.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size,
                         input logic toggle, output logic ok);
    int guard, cyc;
    logic have_saved;
    logic [63:0] s_data; logic [1:0] s_resp; logic s_last;
    rd_data_q.delete(); rd_resp_q.delete(); rd_last_q.delete();
    hold_bad = 0; have_saved = 1'b0; ok = 1'b1; cyc = 0;
    s_data = '0; s_resp = '0; s_last = 1'b0;
    @(negedge clk);
    araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    guard = 0;
    while (!arready && guard < 50) begin @(negedge clk); guard++; end
    if (!arready) ok = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    first_valid = rvalid;
    while (rd_data_q.size() <= int'(len) && cyc < 1000) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (have_saved && rvalid &&
          (rdata !== s_data || rresp !== s_resp || rlast !== s_last)) hold_bad++;
      have_saved = 1'b0;
      if (rvalid && rready) begin
        rd_data_q.push_back(rdata); rd_resp_q.push_back(rresp); rd_last_q.push_back(rlast);
      end else if (rvalid) begin
        have_saved = 1'b1; s_data = rdata; s_resp = rresp; s_last = rlast;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    trailing_valid = rvalid;
    if (rd_data_q.size() != int'(len) + 1) ok = 1'b0;
    $display("read addr=%h len=%0d beats=%0d first_valid=%0b", addr, len, rd_data_q.size(), first_valid);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    checks++; if ({awready, arready} !== 2'b11) $display("FAIL reset_ready: got %b expected 11", {awready, arready}); else passed++;
    checks++; if ({wready, bvalid, rvalid, rlast} !== 4'b0000) $display("FAIL reset_valid: got %b expected 0000", {wready, bvalid, rvalid, rlast}); else passed++;
    checks++; if ({bresp, rresp} !== 4'b0 || rdata !== 64'd0) $display("FAIL reset_data: got bresp=%0d rresp=%0d rdata=%h expected 0", bresp, rresp, rdata); else passed++;
  endtask

  task automatic test_single();
    do_write(32'h10000000, 8'd0, 2'b01, 3'd3, 64'h1122334455667788, 8'hFF, 0, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b00 || !t_ok) $display("FAIL single_bresp: got %0d ok=%0b expected 0", t_resp, t_ok); else passed++;
    do_read(32'h10000000, 8'd0, 2'b01, 3'd3, 1'b0, t_ok);
    checks++; if (first_valid !== 1'b1 || !t_ok) $display("FAIL single_rlatency: got rvalid=%0b ok=%0b expected 1", first_valid, t_ok); else passed++;
    if (t_ok) begin
      checks++; if (rd_data_q[0] !== 64'h1122334455667788 || rd_last_q[0] !== 1'b1 || rd_resp_q[0] !== 2'b00)
        $display("FAIL single_rdata: got %h last=%0b resp=%0d expected 1122334455667788 last=1 resp=0", rd_data_q[0], rd_last_q[0], rd_resp_q[0]);
      else passed++;
    end
  endtask

  task automatic test_burst16();
    do_write(32'h10000040, 8'd15, 2'b01, 3'd3, 64'd0, 8'hFF, 15, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b00 || t_beats != 16) $display("FAIL burst_write: got bresp=%0d beats=%0d expected 0/16", t_resp, t_beats); else passed++;
    do_read(32'h10000040, 8'd15, 2'b01, 3'd3, 1'b1, t_ok);
    checks++; if (!t_ok || trailing_valid) $display("FAIL burst_count: got %0d beats trailing=%0b expected 16/0", rd_data_q.size(), trailing_valid); else passed++;
    checks++; if (hold_bad != 0) $display("FAIL burst_hold: got %0d unstable stalls expected 0", hold_bad); else passed++;
    for (int i = 0; i < rd_data_q.size(); i++) begin
      checks++;
      if (rd_data_q[i] !== 64'(i) || rd_last_q[i] !== (i == 15) || rd_resp_q[i] !== 2'b00)
        $display("FAIL burst_beat%0d: got %h last=%0b resp=%0d expected %h last=%0b resp=0", i, rd_data_q[i], rd_last_q[i], rd_resp_q[i], 64'(i), (i == 15));
      else passed++;
    end
  endtask

  task automatic test_strobe();
    do_write(32'h10000100, 8'd0, 2'b01, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, t_resp, t_beats, t_ok);
    do_write(32'h10000100, 8'd0, 2'b01, 3'd3, 64'd0, 8'h0F, 0, t_resp, t_beats, t_ok);
    do_read(32'h10000100, 8'd0, 2'b01, 3'd3, 1'b0, t_ok);
    checks++; if (!t_ok || rd_data_q[0] !== 64'hFFFFFFFF00000000) $display("FAIL strobe_data: got %h expected ffffffff00000000", t_ok ? rd_data_q[0] : 64'hx); else passed++;
  endtask

  task automatic test_errors();
    do_write(32'h0FFFFFF8, 8'd1, 2'b01, 3'd3, 64'hDEADBEEF00000000, 8'hFF, 1, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b10 || t_beats != 2) $display("FAIL err_low_write: got bresp=%0d beats=%0d expected 2/2", t_resp, t_beats); else passed++;
    do_write(32'h10001FF8, 8'd1, 2'b01, 3'd3, 64'h0, 8'hFF, 1, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b10 || t_beats != 2) $display("FAIL err_high_write: got bresp=%0d beats=%0d expected 2/2", t_resp, t_beats); else passed++;
    do_write(32'h10000000, 8'd0, 2'b01, 3'd2, 64'h0, 8'hFF, 0, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b10) $display("FAIL err_size_write: got bresp=%0d expected 2", t_resp); else passed++;
    do_read(32'h10000000, 8'd0, 2'b01, 3'd3, 1'b0, t_ok);
    checks++; if (!t_ok || rd_data_q[0] !== 64'h1122334455667788) $display("FAIL err_mem_unchanged: got %h expected 1122334455667788", t_ok ? rd_data_q[0] : 64'hx); else passed++;
    do_read(32'h10000040, 8'd2, 2'b10, 3'd3, 1'b0, t_ok);
    checks++; if (!t_ok) $display("FAIL err_read_count: got %0d beats expected 3", rd_data_q.size()); else passed++;
    for (int i = 0; i < rd_data_q.size(); i++) begin
      checks++;
      if (rd_data_q[i] !== 64'd0 || rd_resp_q[i] !== 2'b10 || rd_last_q[i] !== (i == 2))
        $display("FAIL err_read_beat%0d: got %h resp=%0d last=%0b expected 0 resp=2 last=%0b", i, rd_data_q[i], rd_resp_q[i], rd_last_q[i], (i == 2));
      else passed++;
    end
  endtask

  task automatic test_wlast();
    do_write(32'h10000200, 8'd3, 2'b01, 3'd3, 64'h50, 8'hFF, 2, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b10 || t_beats != 4) $display("FAIL wlast_early: got bresp=%0d beats=%0d expected 2/4", t_resp, t_beats); else passed++;
    do_write(32'h10000200, 8'd1, 2'b01, 3'd3, 64'h60, 8'hFF, 9, t_resp, t_beats, t_ok);
    checks++; if (t_resp !== 2'b10 || t_beats != 2) $display("FAIL wlast_missing: got bresp=%0d beats=%0d expected 2/2", t_resp, t_beats); else passed++;
  endtask

  task automatic test_concurrent_reset();
    do_write(32'h10000300, 8'd0, 2'b01, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 0, t_resp, t_beats, t_ok);
    @(negedge clk);
    awaddr = 32'h10000300; awlen = 8'd0; awburst = 2'b01; awsize = 3'd3; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 64'hBBBBBBBBBBBBBBBB; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h10000300; arlen = 8'd0; arburst = 2'b01; arsize = 3'd3; arvalid = 1'b1;
    checks++; if ({wready, arready} !== 2'b11) $display("FAIL coll_ready: got %b expected 11", {wready, arready}); else passed++;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    checks++; if (rvalid !== 1'b1 || rdata !== 64'hAAAAAAAAAAAAAAAA) $display("FAIL coll_old_data: got rvalid=%0b %h expected 1 aaaaaaaaaaaaaaaa", rvalid, rdata); else passed++;
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) $display("FAIL coll_bresp: got bvalid=%0b bresp=%0d expected 1/0", bvalid, bresp); else passed++;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    $display("collision write/read addr=10000300 done");
    do_read(32'h10000300, 8'd0, 2'b01, 3'd3, 1'b0, t_ok);
    checks++; if (!t_ok || rd_data_q[0] !== 64'hBBBBBBBBBBBBBBBB) $display("FAIL coll_new_data: got %h expected bbbbbbbbbbbbbbbb", t_ok ? rd_data_q[0] : 64'hx); else passed++;
    // Reset in the middle of an 8-beat read burst.
    @(negedge clk);
    araddr = 32'h10000040; arlen = 8'd7; arburst = 2'b01; arsize = 3'd3; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1; rready = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) $display("FAIL midreset_state: got rvalid=%0b arready=%0b expected 0/1", rvalid, arready); else passed++;
    $display("reset applied mid read burst");
    do_read(32'h10000040, 8'd1, 2'b01, 3'd3, 1'b0, t_ok);
    checks++;
    if (!t_ok || rd_data_q[0] !== 64'd0 || rd_data_q[1] !== 64'd1 || rd_last_q[1] !== 1'b1 || rd_resp_q[1] !== 2'b00)
      $display("FAIL midreset_newburst: got ok=%0b beats=%0d expected data 0,1 with rlast on beat 2", t_ok, rd_data_q.size());
    else passed++;
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    test_reset();
    test_single();
    test_burst16();
    test_strobe();
    test_errors();
    test_wlast();
    test_concurrent_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
